// File: rtl/fp_pkg.sv
// Shared IEEE-754 single-precision field definitions used by the
// fixed-to-float converter (optional rounding macro: FIX2FLT_RNE_EN).
package fp_pkg;

   localparam int SIGN_W   = 1;
   localparam int EXP_W    = 8;
   localparam int MANT_W   = 23;
   localparam int EXP_BIAS = 127;

   typedef struct packed {
      logic              sign;
      logic [EXP_W-1:0]  exp;
      logic [MANT_W-1:0] mant;
   } float32_t;

   localparam float32_t FP32_ZERO = '{sign: 1'b0, exp: '0, mant: '0};

   function automatic float32_t fp32_pack(input logic              s,
                                          input logic [EXP_W-1:0]  e,
                                          input logic [MANT_W-1:0] m);
      float32_t f;
      f.sign = s;
      f.exp  = e;
      f.mant = m;
      return f;
   endfunction

endpackage

// File: rtl/lzc.sv
// Combinational leading-zero counter. o_cnt = W when the input is all zero.
module lzc #(
   parameter int W     = 33,
   parameter int CNT_W = $clog2(W + 1)
) (
   input  logic [W-1:0]     i_data,
   output logic [CNT_W-1:0] o_cnt,
   output logic             o_zero
);

   // scan upward so the highest set bit is the last one to win
   always_comb begin
      o_cnt  = CNT_W'(W);
      o_zero = 1'b1;
      for (int i = 0; i < W; i++) begin
         if (i_data[i]) begin
            o_cnt  = CNT_W'(W - 1 - i);
            o_zero = 1'b0;
         end
      end
   end

endmodule

// File: rtl/fix_to_float32.sv
// Pipelined signed fixed-point to IEEE-754 single converter.
// Stages: sign/magnitude -> normalise -> exponent/mantissa (+round decision)
// -> round/pack into the output register. Latency 3 cycles after capture.
// Optional build macro FIX2FLT_RNE_EN selects round-to-nearest-even;
// without it the magnitude is truncated and no carry logic exists.
module fix_to_float32
   import fp_pkg::*;
#(
   parameter int IN_W      = 32,
   parameter int FRAC_BITS = 30
) (
   input  logic            clk,
   input  logic            reset,
   input  logic            in_valid,
   input  logic [IN_W-1:0] fix_in,
   output logic            out_valid,
   output logic [31:0]     float_out
);

   localparam int STAGES = 4;
   localparam int MAG_W  = IN_W + 1;
   // room for hidden bit, mantissa, guard and at least one sticky bit
   localparam int NORM_W = (MAG_W < MANT_W + 3) ? MANT_W + 3 : MAG_W;
   localparam int LZ_W   = $clog2(MAG_W + 1);
   // exponent when the magnitude msb sits in the top bit (lz = 0)
   localparam int EXP_TOP = EXP_BIAS + MAG_W - 1 - FRAC_BITS;

   logic [STAGES:1] r_vld_pipe;

   // ---------------- stage 1: sign / magnitude ----------------
   logic [MAG_W-1:0] w_sx;
   logic [MAG_W-1:0] w_mag;
   logic             r1_sign;
   logic [MAG_W-1:0] r1_mag;

   assign w_sx  = {fix_in[IN_W-1], fix_in};
   assign w_mag = fix_in[IN_W-1] ? (MAG_W'(0) - w_sx) : w_sx;

   // capture sign and one-bit-wider magnitude (most-negative input fits)
   always_ff @(posedge clk or negedge reset) begin
      if (!reset) begin
         r1_sign <= 1'b0;
         r1_mag  <= '0;
      end else begin
         r1_sign <= fix_in[IN_W-1];
         r1_mag  <= w_mag;
      end
   end

   // ---------------- stage 2: normalise ----------------
   logic [LZ_W-1:0]   w_lz;
   logic              w_zero;
   logic [NORM_W-1:0] w_ext;
   logic [NORM_W-1:0] w_norm;
   logic              r2_sign;
   logic              r2_zero;
   logic [LZ_W-1:0]   r2_lz;
   logic [NORM_W-1:0] r2_norm;

   lzc #(.W(MAG_W), .CNT_W(LZ_W)) u_lzc (
      .i_data (r1_mag),
      .o_cnt  (w_lz),
      .o_zero (w_zero)
   );

   assign w_ext  = NORM_W'(r1_mag) << (NORM_W - MAG_W);
   assign w_norm = w_ext << w_lz;

   // left-justify the magnitude so its msb becomes the hidden bit
   always_ff @(posedge clk or negedge reset) begin
      if (!reset) begin
         r2_sign <= 1'b0;
         r2_zero <= 1'b0;
         r2_lz   <= '0;
         r2_norm <= '0;
      end else begin
         r2_sign <= r1_sign;
         r2_zero <= w_zero;
         r2_lz   <= w_lz;
         r2_norm <= w_norm;
      end
   end

   // ---------------- stage 3: exponent, mantissa, round decision ----------------
   logic [MANT_W-1:0] w_mant;
   logic [EXP_W-1:0]  w_exp;
   logic              w_unused;
   logic              r3_sign;
   logic              r3_zero;
   logic [EXP_W-1:0]  r3_exp;
   logic [MANT_W-1:0] r3_mant;

   assign w_mant = r2_norm[NORM_W-2 -: MANT_W];
   assign w_exp  = EXP_W'(EXP_TOP - int'(r2_lz));

`ifdef FIX2FLT_RNE_EN
   logic w_guard;
   logic w_sticky;
   logic w_rnd_up;
   logic r3_rnd_up;

   assign w_guard  = r2_norm[NORM_W-2-MANT_W];
   assign w_sticky = |r2_norm[NORM_W-3-MANT_W:0];
   assign w_rnd_up = w_guard & (w_sticky | w_mant[0]);
   assign w_unused = r2_norm[NORM_W-1];

   // remember whether this sample must be incremented in the last stage
   always_ff @(posedge clk or negedge reset) begin
      if (!reset) r3_rnd_up <= 1'b0;
      else        r3_rnd_up <= w_rnd_up;
   end
`else
   // hidden bit and discarded bits are dropped in the truncating build
   assign w_unused = r2_norm[NORM_W-1] ^ (^r2_norm[NORM_W-2-MANT_W:0]);
`endif

   // register unrounded fields; zero forces a positive zero result
   always_ff @(posedge clk or negedge reset) begin
      if (!reset) begin
         r3_sign <= 1'b0;
         r3_zero <= 1'b0;
         r3_exp  <= '0;
         r3_mant <= '0;
      end else begin
         r3_sign <= r2_sign & ~r2_zero;
         r3_zero <= r2_zero;
         r3_exp  <= w_exp;
         r3_mant <= w_mant;
      end
   end

   // ---------------- stage 4: round / pack ----------------
   logic [MANT_W-1:0] w_mant_fin;
   logic [EXP_W-1:0]  w_exp_fin;
   float32_t          w_result;
   float32_t          r_float;

`ifdef FIX2FLT_RNE_EN
   logic w_carry;

   // mantissa overflow wraps to zero and bumps the exponent
   assign {w_carry, w_mant_fin} = {1'b0, r3_mant} + (MANT_W + 1)'(r3_rnd_up);
   assign w_exp_fin             = r3_exp + EXP_W'(w_carry);
`else
   assign w_mant_fin = r3_mant;
   assign w_exp_fin  = r3_exp;
`endif

   assign w_result = r3_zero ? FP32_ZERO : fp32_pack(r3_sign, w_exp_fin, w_mant_fin);

   // output word updates only on valid samples, otherwise holds
   always_ff @(posedge clk or negedge reset) begin
      if (!reset)                   r_float <= FP32_ZERO;
      else if (r_vld_pipe[STAGES-1]) r_float <= w_result;
   end

   // valid shift register; bubbles travel alongside the data
   always_ff @(posedge clk or negedge reset) begin
      if (!reset) r_vld_pipe <= '0;
      else        r_vld_pipe <= {r_vld_pipe[STAGES-1:1], in_valid};
   end

   assign out_valid = r_vld_pipe[STAGES];
   assign float_out = r_float;

endmodule

// File: doc/fix_to_float32.md
Name: fix_to_float32

Overview:
- Pipelined converter that sits directly downstream of the unrolled CORDIC stage.
- Takes the CORDIC's signed fixed-point cosine result and produces an IEEE-754 single-precision word for the floating-point datapath.
- Fully pipelined: accepts one sample per clock, fixed latency, no backpressure.

Parameters:
- IN_W, 32, input word width (two's complement).
- FRAC_BITS, 30, number of fractional bits in the input (Q2.30 by default: 0x40000000 = 1.0).

Ports:
- clk  in  1  system clock, all state on rising edge.
- reset  in  1  asynchronous, active-low reset; clears all pipeline state immediately.
- in_valid  in  1  qualifies fix_in on the current rising edge.
- fix_in  in  IN_W  signed fixed-point sample (CORDIC cos_out).
- out_valid  out  1  one-cycle pulse marking a valid float_out.
- float_out  out  32  IEEE-754 single {sign, exp[7:0], mant[22:0]}.

Behaviour:
- Reset (reset=0, asynchronous): out_valid=0, float_out=32'h0, all internal valid bits=0. In-flight samples are discarded, not emitted after reset release.
- Latency: exactly 3 cycles. A sample taken at edge N with in_valid=1 appears with out_valid=1 after edge N+3. Back-to-back inputs give back-to-back outputs.
- float_out holds its last value when out_valid=0.
- Stage 1 (sign/magnitude):
  - sign = fix_in[IN_W-1].
  - mag = |fix_in| computed at IN_W+1 bits, so the most-negative input (0x80000000) yields magnitude 2^31 without overflow.
- Stage 2 (normalise): leading-zero count on mag gives msb position p; mag is left-shifted so that bit p lands in the hidden-bit position.
- Stage 3 (round/pack):
  - exp = 127 + p − FRAC_BITS.
  - mant = the 23 bits below the hidden bit.
  - Rounding is applied per the optional feature.
  - Mantissa carry-out on rounding: mant=0 and exp+1.
- Zero input: float_out = 32'h00000000. Negative zero is never produced.
- With default parameters, exp ranges 97..128. No denormal, infinity or NaN outputs are possible; none are generated.
- in_valid=0 cycles propagate as bubbles; pipeline registers still advance every cycle.

Optional Feature:
- Macro FIX2FLT_RNE_EN.
- Defined: round-to-nearest-even.
  - Guard = first discarded bit; sticky = OR of the remaining discarded bits.
  - Round up if guard & (sticky | mant_lsb).
- Undefined: truncation toward zero of magnitude; discarded bits ignored, no carry logic synthesised.
- Latency is 3 cycles in both builds.

Decomposition:
- Shared package fp_pkg:
  - float32 field widths (SIGN=1, EXP_W=8, MANT_W=23).
  - EXP_BIAS=127.
  - packed float32 typedef.
  - constant FP32_ZERO.
- Sub-module lzc: parameterised leading-zero counter, combinational, instantiated in stage 2.

Test Plan:
- Basic values, one per cycle: 0x20000000, 0x40000000, 0xC0000000, 0x00000000 -> 0x3F000000, 0x3F800000, 0xBF800000, 0x00000000 on four consecutive out_valid pulses, 3 cycles after each input.
- Extremes: 0x80000000 -> 0xC0000000 (−2.0); 0x00000001 -> 0x30800000 (2^-30).
- Rounding with FIX2FLT_RNE_EN:
  - 0x7FFFFFFF -> 0x40000000 (carry into exponent).
  - 0x40000040 -> 0x3F800000 (tie, even lsb, down).
  - 0x400000C0 -> 0x3F800002 (tie, odd lsb, up).
- Without FIX2FLT_RNE_EN: 0x7FFFFFFF -> 0x3FFFFFFF; 0x400000C0 -> 0x3F800001.
- Bubbles: in_valid pattern 1,0,1,1,0 -> out_valid pattern 1,0,1,1,0 shifted by exactly 3 cycles, with correct data per pulse.
- Reset mid-flight: drive 3 valid samples, assert reset asynchronously between edges -> out_valid and float_out go to 0 immediately. After release with in_valid=0, no stale out_valid ever appears.
